// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } state_e;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; index 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/seg7_scan_mux_hex_decode.sv
// Purely combinational hex-to-seven-segment decoder (active-low outputs).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg_n = hex_to_seg(code);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment display driver: scans NUM_DIGITS common-anode
// digits with blanking gaps, showing one of NUM_SRC sources snapshotted per frame.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_SRC      = 2,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int SELW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_SRC*NUM_DIGITS*4-1:0] src_data,
  input  logic [SELW-1:0]               src_sel,
  output logic [NUM_DIGITS-1:0]         dig_n,
  output logic [6:0]                    seg_n,
  output logic                          frame_start
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam int IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BUFW    = NUM_DIGITS * 4;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] SHOW_LAST  = CNTW'(PRESCALE - 1);
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDXW-1:0] IDX_ONE    = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

  // Control and frame registers.
  state_e            state_q, state_d;
  logic              started_q, started_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [BUFW-1:0]   buf_q, buf_d;
  logic [SELW-1:0]   sel_q, sel_d;

  // Registered outputs.
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  frame_start_q, frame_start_d;

  // Decode path helpers.
  logic [SELW-1:0] sel_in;
  logic [BUFW-1:0] src_frame;
  logic [3:0]      digit_code;
  logic [6:0]      digit_seg;

  // Out-of-range select values fall back to source 0.
  always_comb begin
    sel_in = (32'(src_sel) < 32'(NUM_SRC)) ? src_sel : '0;
  end

  // Gather the selected source's digit codes into one frame-wide word.
  always_comb begin
    src_frame = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (sel_in == SELW'(s)) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          src_frame[d*4 +: 4] = src_data[(s*NUM_DIGITS + d)*4 +: 4];
        end
      end
    end
  end

  // Next-state logic: LOAD snapshots, BLANK darkens, SHOW lights one digit.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    sel_d     = sel_q;
    unique case (state_q)
      LOAD: begin
        // The first clock after reset makes the LOAD cycle visible before acting on it.
        if (started_q) begin
          sel_d   = sel_in;
          buf_d   = src_frame;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = HAS_BLANK ? BLANK : SHOW;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = HAS_BLANK ? BLANK : SHOW;
          end else if (en) begin
            state_d = LOAD;
          end else begin
            state_d = OFF;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OFF: begin
        if (en) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Pick the digit code that will be lit in the next cycle.
  always_comb begin
    digit_code = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_d == IDXW'(d)) begin
        digit_code = buf_d[d*4 +: 4];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .code  (digit_code),
    .seg_n (digit_seg)
  );

  // Output values for the next cycle, so registered outputs track the state they belong to.
  always_comb begin
    dig_n_d       = '1;
    seg_n_d       = SEG_OFF;
    frame_start_d = (state_d == LOAD);
    if (state_d == SHOW) begin
      seg_n_d = digit_seg;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (idx_d == IDXW'(d)) begin
          dig_n_d[d] = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      started_q     <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      sel_q         <= '0;
      dig_n_q       <= '1;
      seg_n_q       <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      sel_q         <= sel_d;
      dig_n_q       <= dig_n_d;
      seg_n_q       <= seg_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dig_n       = dig_n_q;
  assign seg_n       = seg_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised multiplexed seven-segment display driver. It time-division scans `NUM_DIGITS` common-anode digits and selects one of `NUM_SRC` digit-code sources. It inserts programmable blanking between digits to suppress ghosting. Source selection and digit data are snapshotted once per frame, so a frame never mixes sources or half-updated values. It is the successor to the fixed 4-digit, 2-source scan/mux top and sits between the drink/sensor code generators and the board's anode/segment pins.

## Interface
- `NUM_DIGITS`, default 4: digits scanned per frame, ≥1.
- `NUM_SRC`, default 2: selectable sources, ≥1.
- `PRESCALE`, default 50000: clocks each digit is lit, ≥1.
- `BLANK_CYCLES`, default 500: all-off clocks before each digit, ≥0.
- `SELW`, default `$clog2(NUM_SRC)` (1 if NUM_SRC==1): width of `src_sel`.

- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: display enable.
- `src_data`  in  NUM_SRC*NUM_DIGITS*4: hex code, source s digit d at bits `[(s*NUM_DIGITS+d)*4 +: 4]`.
- `src_sel`  in  SELW: source index. Values ≥NUM_SRC select source 0.
- `dig_n`  out  NUM_DIGITS: anode enables, active-low, at most one bit low.
- `seg_n`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `frame_start`  out  1: one-cycle pulse while in LOAD.

## Operation
- States: OFF, LOAD, BLANK, SHOW. Registers: digit index `idx`, cycle counter `cnt`, frame buffer of NUM_DIGITS×4 bits, latched select.
- Reset: state=LOAD, idx=0, cnt=0, buffer=0, latched select=0. Outputs during reset: `dig_n`=all 1, `seg_n`=7'h7F, `frame_start`=0.
- LOAD (1 cycle):
  - Latches `src_sel` and copies that source's NUM_DIGITS codes into the buffer. idx=0.
  - `frame_start`=1. All digits off.
  - Next state: BLANK, or SHOW if BLANK_CYCLES==0.
- BLANK (BLANK_CYCLES cycles): `dig_n` all 1, `seg_n`=7'h7F. Then SHOW.
- SHOW (PRESCALE cycles):
  - `dig_n[idx]`=0, all other bits 1.
  - `seg_n`=hex decode of buffer digit idx.
  - At the last cycle:
    - If idx<NUM_DIGITS-1: idx+1, go to BLANK (or SHOW if BLANK_CYCLES==0).
    - Else, if `en`=1: go to LOAD.
    - Else: go to OFF.
- OFF: all digits off, `seg_n`=7'h7F. When `en`=1, go to LOAD.
- `en` is sampled only at the end of the last digit's SHOW and while in OFF. A deassertion mid-frame completes the frame.
- Changes to `src_sel` or `src_data` mid-frame have no visible effect until the next LOAD.
- Hex decode, active-low `{g..a}`:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Reset asserted mid-operation: all outputs go off immediately (asynchronous). After release, the block restarts at LOAD.

## Timing
- All outputs are registered and change only on `clk` rising edges. No combinational path from inputs to outputs.
- Outputs reflect the current state in the same cycle that state is active.
- Frame length with `en` held high: 1 + NUM_DIGITS×(BLANK_CYCLES+PRESCALE) cycles.
- First LOAD occurs on the first rising edge after `rst_n` is released. The first digit lights BLANK_CYCLES+1 cycles after LOAD.
- Source switch latency: applied at the next LOAD. Worst case is one full frame.
- No handshake. Inputs are assumed synchronous to `clk`; switch and sensor synchronisers sit upstream.

## Structure
- Package `seg7_pkg`:
  - State enum `{OFF, LOAD, BLANK, SHOW}`.
  - The 16-entry active-low segment constant table.
  - Constant `SEG_OFF`=7'h7F.
- Sub-module `seg7_hex_decode`: 4-bit code in, 7-bit active-low segments out, purely combinational. Instantiated once on the buffer-selected digit.
- Counter widths: `cnt` is `$clog2(max(PRESCALE,BLANK_CYCLES)+1)` bits; `idx` is `$clog2(NUM_DIGITS)` bits (min 1).

## Test plan
Bench parameters: NUM_DIGITS=4, NUM_SRC=2, PRESCALE=4, BLANK_CYCLES=1.
- Reset then release, `en`=1, src_sel=0, source 0 codes = 3,2,1,0:
  - `frame_start` pulses every 21 cycles.
  - `dig_n` sequence 1110, 1101, 1011, 0111, each held 4 cycles with 1 blank cycle before each.
  - `seg_n` = 30, 24, 79, 40.
- Toggle `src_sel` to 1 mid-frame (source 1 = 8,8,8,8): current frame completes unchanged. Next frame shows `seg_n`=00 on all digits.
- Change `src_data` of the active source mid-frame: the change appears only after the next `frame_start`.
- Drop `en` during digit 1: the frame finishes through digit 3, then `dig_n`=1111 and `seg_n`=7F hold. Raise `en`: LOAD is next cycle, digit 0 lights 2 cycles later.
- Assert `rst_n`=0 during SHOW: `dig_n`=1111 and `seg_n`=7F before the next clock edge. Restart at LOAD after release.
- Rebuild with BLANK_CYCLES=0 and `src_sel`=3 (out of range with SELW=2, NUM_SRC=2):
  - Source 0 is shown.
  - No blank cycles appear.
  - Frame length is 17 cycles.
